tstate_seq: RTL and testbench
=============================

Name: tstate_seq

Overview:
- Parametrised 8085-class T-state/machine-cycle sequencer. Next generation of the core's fixed 6-state machine.
- Steps each machine cycle through T1..Tn with a programmable cycle length, WAIT insertion with optional timeout, HOLD/HLDA, HALT and interrupt-acknowledge entry.
- Drives ALE, RD/WR/INTA strobes, PC-increment and the S-status pins.
- Sits between the instruction decoder, which supplies the per-cycle descriptor, and the external bus pins.

Parameters:
MAX_T, 6, maximum T-states per machine cycle (legal 4..15).
WAIT_LIMIT, 0, max consecutive TW cycles before forced exit; 0 = unlimited.
HOLD_ANY, 0, 1 = HOLD honoured at end of every machine cycle; 0 = only at end of last machine cycle of an instruction.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
mc_type  in  3  next cycle type: 0 fetch, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 int ack, 6 bus idle
mc_len  in  4  T-states in next cycle (3..MAX_T)
mc_last  in  1  next cycle is last of instruction
mc_incpc  in  1  pulse inc_pc in next cycle
halt_req  in  1  decoder requests HALT after current cycle
int_req  in  1  accepted interrupt pending
ready  in  1  READY pin
hold  in  1  HOLD pin
tnum  out  4  current T-state number (0 = reset/hold/halt, 1..MAX_T)
in_wait  out  1  in TW
in_hold  out  1  in HOLD (also HLDA pin)
in_halt  out  1  in HALT
status  out  3  latched mc_type of current cycle; 7 while halted
ale  out  1  high during T1
rd  out  1  read strobe
wr  out  1  write strobe
inta  out  1  interrupt-ack strobe
inc_pc  out  1  one-cycle PC increment pulse
cyc_done  out  1  one-cycle pulse in final T-state of a cycle
wait_tmo  out  1  one-cycle pulse on forced WAIT exit

Behaviour:
- State set: RST, T1..T(MAX_T), TW, HOLD, HALT. All outputs registered.
- Reset: state = RST, tnum = 0, status = 0, all strobes/flags/pulses = 0, wait counter = 0. Reset mid-cycle aborts immediately with no completion pulse.
- RST -> T1 on the first clock with reset low.
- Entering T1: latch mc_type, mc_len, mc_last, mc_incpc; status <= mc_type.
- mc_len < 3 is treated as 3. mc_len > MAX_T is treated as MAX_T.
- T1: ale = 1. Always -> T2.
- T2 -> T3 if ready = 1 or type = 6; else -> TW.
- TW: in_wait = 1; counter increments each cycle.
  - ready = 1 -> T3.
  - If WAIT_LIMIT != 0 and count reaches WAIT_LIMIT: -> T3 and pulse wait_tmo.
  - Counter clears on leaving TW.
- T3 .. T(len-1): advance to the next T-state. T(len) is the final T-state.
- Final T-state:
  - cyc_done = 1.
  - Next state priority: hold (and, if HOLD_ANY = 0, latched mc_last) -> HOLD; else halt_req -> HALT; else -> T1.
- Strobes:
  - rd: types 0/1/3 during T2, TW and T3.
  - wr: types 2/4 during T2, TW and T3.
  - inta: type 5 during T2, TW and T3.
  - Type 6 asserts no strobes.
  - inc_pc: single pulse in the first T2 cycle if mc_incpc was latched.
- HOLD:
  - tnum = 0, in_hold = 1, strobes low, status held.
  - Exit when hold = 0: -> HALT if entered from HALT; else -> T1.
- HALT:
  - status = 7, tnum = 0, in_halt = 1.
  - hold = 1 -> HOLD (remembers HALT).
  - Else int_req = 1 -> T1; the decoder supplies type 5.
  - hold and int_req together: HOLD wins.
- Simultaneous hold and halt_req at final T-state: HOLD first, then HALT on release.

Test Plan:
- Reset then mc_type = 0, len = 4, ready = 1 -> tnum 1,2,3,4,1; ale at T1; rd at T2–T3; cyc_done at T4; status = 0.
- mem rd, len = 3, ready low 3 cycles -> T1, T2, TW×3, T3; rd high throughout; in_wait for 3 cycles.
- WAIT_LIMIT = 2, ready stuck low -> two TW cycles, then T3 with wait_tmo pulse; counter cleared on next cycle.
- mc_len = 9 with MAX_T = 6 -> cycle ends at T6. mc_len = 1 -> cycle ends at T3.
- HOLD_ANY = 0: hold high with mc_last = 0 -> no HOLD. With mc_last = 1 -> HOLD entered, in_hold = 1; hold low -> T1.
- halt_req at final T-state -> HALT, status = 7; hold pulse -> HOLD then back to HALT; int_req -> T1; reset asserted during T3 -> RST next cycle with all outputs 0.

Source files
------------

// File: rtl/tstate_seq_if.sv
// Bus and descriptor bundle for the T-state sequencer.
// "master" is the sequencer side; "slave" is the decoder/pin side.
interface tstate_seq_if;
    logic [2:0] mc_type;
    logic [3:0] mc_len;
    logic       mc_last;
    logic       mc_incpc;
    logic       halt_req;
    logic       int_req;
    logic       ready;
    logic       hold;

    logic [3:0] tnum;
    logic       in_wait;
    logic       in_hold;
    logic       in_halt;
    logic [2:0] status;
    logic       ale;
    logic       rd;
    logic       wr;
    logic       inta;
    logic       inc_pc;
    logic       cyc_done;
    logic       wait_tmo;

    modport master (
        input  mc_type, mc_len, mc_last, mc_incpc, halt_req, int_req, ready, hold,
        output tnum, in_wait, in_hold, in_halt, status, ale, rd, wr, inta,
               inc_pc, cyc_done, wait_tmo
    );

    modport slave (
        output mc_type, mc_len, mc_last, mc_incpc, halt_req, int_req, ready, hold,
        input  tnum, in_wait, in_hold, in_halt, status, ale, rd, wr, inta,
               inc_pc, cyc_done, wait_tmo
    );
endinterface

// File: rtl/tstate_seq.sv
// 8085-class T-state / machine-cycle sequencer with programmable cycle length,
// WAIT insertion (optional timeout), HOLD/HLDA, HALT and interrupt-acknowledge entry.
module tstate_seq #(
    parameter int MAX_T      = 6,
    parameter int WAIT_LIMIT = 0,
    parameter int HOLD_ANY   = 0
) (
    input  logic         clock,
    input  logic         reset,
    tstate_seq_if.master bus
);

    typedef enum logic [2:0] {
        ST_RST,
        ST_TSTATE,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } state_t;

    localparam int         WCW     = 16;
    localparam logic [3:0] MAX_T_L = 4'(MAX_T);

    state_t           state, state_nxt;
    logic [3:0]       tcur, tcur_nxt;
    logic [2:0]       cur_type;
    logic [3:0]       cur_len;
    logic             cur_last;
    logic             cur_incpc;
    logic             from_halt, from_halt_nxt;
    logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
    logic             load_desc;
    logic             tmo_nxt;
    logic [2:0]       type_nxt;
    logic [3:0]       len_nxt;
    logic             strobe_nxt;

    logic [3:0]       tnum_q;
    logic             in_wait_q, in_hold_q, in_halt_q;
    logic [2:0]       status_q;
    logic             ale_q, rd_q, wr_q, inta_q, inc_pc_q, cyc_done_q, wait_tmo_q;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < 4'd3)
            return 4'd3;
        else if (len > MAX_T_L)
            return MAX_T_L;
        else
            return len;
    endfunction

    // Next-state decode; TW keeps tcur at 2 so tnum shows the T-state being stretched.
    always_comb begin
        state_nxt     = state;
        tcur_nxt      = tcur;
        from_halt_nxt = from_halt;
        wait_cnt_nxt  = '0;
        load_desc     = 1'b0;
        tmo_nxt       = 1'b0;

        case (state)
            ST_RST: begin
                state_nxt = ST_TSTATE;
                tcur_nxt  = 4'd1;
                load_desc = 1'b1;
            end

            ST_TSTATE: begin
                if (tcur == cur_len) begin
                    if (bus.hold && ((HOLD_ANY != 0) || cur_last)) begin
                        state_nxt     = ST_HOLD;
                        tcur_nxt      = 4'd0;
                        from_halt_nxt = bus.halt_req;
                    end else if (bus.halt_req) begin
                        state_nxt = ST_HALT;
                        tcur_nxt  = 4'd0;
                    end else begin
                        tcur_nxt  = 4'd1;
                        load_desc = 1'b1;
                    end
                end else if (tcur == 4'd2 && !bus.ready && cur_type != 3'd6) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WCW'(1);
                end else begin
                    tcur_nxt = tcur + 4'd1;
                end
            end

            ST_WAIT: begin
                if (bus.ready) begin
                    state_nxt = ST_TSTATE;
                    tcur_nxt  = 4'd3;
                end else if ((WAIT_LIMIT != 0) && (wait_cnt >= WCW'(WAIT_LIMIT))) begin
                    state_nxt = ST_TSTATE;
                    tcur_nxt  = 4'd3;
                    tmo_nxt   = 1'b1;
                end else begin
                    wait_cnt_nxt = (&wait_cnt) ? wait_cnt : wait_cnt + WCW'(1);
                end
            end

            ST_HOLD: begin
                if (!bus.hold) begin
                    if (from_halt) begin
                        state_nxt     = ST_HALT;
                        from_halt_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_TSTATE;
                        tcur_nxt  = 4'd1;
                        load_desc = 1'b1;
                    end
                end
            end

            ST_HALT: begin
                if (bus.hold) begin
                    state_nxt     = ST_HOLD;
                    from_halt_nxt = 1'b1;
                end else if (bus.int_req) begin
                    state_nxt = ST_TSTATE;
                    tcur_nxt  = 4'd1;
                    load_desc = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_RST;
                tcur_nxt  = 4'd0;
            end
        endcase

        type_nxt   = load_desc ? bus.mc_type : cur_type;
        len_nxt    = load_desc ? clamp_len(bus.mc_len) : cur_len;
        strobe_nxt = (state_nxt == ST_WAIT) ||
                     (state_nxt == ST_TSTATE && (tcur_nxt == 4'd2 || tcur_nxt == 4'd3));
    end

    // State, latched descriptor and every output register update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RST;
            tcur       <= 4'd0;
            cur_type   <= 3'd0;
            cur_len    <= 4'd3;
            cur_last   <= 1'b0;
            cur_incpc  <= 1'b0;
            from_halt  <= 1'b0;
            wait_cnt   <= '0;
            tnum_q     <= 4'd0;
            in_wait_q  <= 1'b0;
            in_hold_q  <= 1'b0;
            in_halt_q  <= 1'b0;
            status_q   <= 3'd0;
            ale_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            inta_q     <= 1'b0;
            inc_pc_q   <= 1'b0;
            cyc_done_q <= 1'b0;
            wait_tmo_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tcur      <= tcur_nxt;
            from_halt <= from_halt_nxt;
            wait_cnt  <= wait_cnt_nxt;

            if (load_desc) begin
                cur_type  <= bus.mc_type;
                cur_len   <= clamp_len(bus.mc_len);
                cur_last  <= bus.mc_last;
                cur_incpc <= bus.mc_incpc;
            end

            tnum_q    <= (state_nxt == ST_TSTATE || state_nxt == ST_WAIT) ? tcur_nxt : 4'd0;
            in_wait_q <= (state_nxt == ST_WAIT);
            in_hold_q <= (state_nxt == ST_HOLD);
            in_halt_q <= (state_nxt == ST_HALT);

            if (load_desc)
                status_q <= bus.mc_type;
            else if (state_nxt == ST_HALT)
                status_q <= 3'd7;

            ale_q      <= (state_nxt == ST_TSTATE) && (tcur_nxt == 4'd1);
            rd_q       <= strobe_nxt && (type_nxt == 3'd0 || type_nxt == 3'd1 || type_nxt == 3'd3);
            wr_q       <= strobe_nxt && (type_nxt == 3'd2 || type_nxt == 3'd4);
            inta_q     <= strobe_nxt && (type_nxt == 3'd5);
            inc_pc_q   <= (state == ST_TSTATE) && (tcur == 4'd1) && cur_incpc;
            cyc_done_q <= (state_nxt == ST_TSTATE) && (tcur_nxt == len_nxt);
            wait_tmo_q <= tmo_nxt;
        end
    end

    assign bus.tnum     = tnum_q;
    assign bus.in_wait  = in_wait_q;
    assign bus.in_hold  = in_hold_q;
    assign bus.in_halt  = in_halt_q;
    assign bus.status   = status_q;
    assign bus.ale      = ale_q;
    assign bus.rd       = rd_q;
    assign bus.wr       = wr_q;
    assign bus.inta     = inta_q;
    assign bus.inc_pc   = inc_pc_q;
    assign bus.cyc_done = cyc_done_q;
    assign bus.wait_tmo = wait_tmo_q;

endmodule

// File: tb/tb_tstate_seq.sv
// Cycle-by-cycle scoreboard bench for tstate_seq (MAX_T=6, WAIT_LIMIT=4, HOLD_ANY=0).
module tb_tstate_seq;

    logic clock;
    logic reset;

    tstate_seq_if bus ();

    tstate_seq #(
        .MAX_T      (6),
        .WAIT_LIMIT (4),
        .HOLD_ANY   (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Flag bits of an expected vector: {tnum, status, flags}
    localparam logic [9:0] F_WAIT = 10'b10_0000_0000;
    localparam logic [9:0] F_HOLD = 10'b01_0000_0000;
    localparam logic [9:0] F_HALT = 10'b00_1000_0000;
    localparam logic [9:0] F_ALE  = 10'b00_0100_0000;
    localparam logic [9:0] F_RD   = 10'b00_0010_0000;
    localparam logic [9:0] F_WR   = 10'b00_0001_0000;
    localparam logic [9:0] F_INTA = 10'b00_0000_1000;
    localparam logic [9:0] F_INC  = 10'b00_0000_0100;
    localparam logic [9:0] F_DONE = 10'b00_0000_0010;
    localparam logic [9:0] F_TMO  = 10'b00_0000_0001;

    int pass_count  = 0;
    int check_count = 0;

    logic [16:0] exp_q[$];
    string       tag_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [16:0] mk(input int t, input int st, input logic [9:0] f);
        return {4'(t), 3'(st), f};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.tnum, bus.status, bus.in_wait, bus.in_hold, bus.in_halt, bus.ale,
                bus.rd, bus.wr, bus.inta, bus.inc_pc, bus.cyc_done, bus.wait_tmo};
    endfunction

    task automatic checkOutput(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        check_count++;
        if (obs === exp)
            pass_count++;
        else
            $display("[TB] FAIL %s: got {tnum,status,flags}=%b expected %b", tag, obs, exp);
    endtask

    task automatic setDesc(input int t, input int len, input logic last, input logic incpc);
        bus.mc_type  = 3'(t);
        bus.mc_len   = 4'(len);
        bus.mc_last  = last;
        bus.mc_incpc = incpc;
    endtask

    // Queue the expectation for the next edge, clock once, then compare.
    task automatic applyStimulus(input string tag, input logic [16:0] exp);
        logic [16:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput(t, observed(), e);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.halt_req = 1'b0;
        bus.int_req  = 1'b0;
        bus.ready    = 1'b1;
        bus.hold     = 1'b0;
        setDesc(0, 4, 1'b0, 1'b1);

        applyStimulus("reset0", mk(0, 0, '0));
        applyStimulus("reset1", mk(0, 0, '0));

        // Opcode fetch, 4 T-states, PC increment
        reset = 1'b0;
        applyStimulus("fetch_t1", mk(1, 0, F_ALE));
        setDesc(1, 3, 1'b0, 1'b0);
        applyStimulus("fetch_t2", mk(2, 0, F_RD | F_INC));
        applyStimulus("fetch_t3", mk(3, 0, F_RD));
        applyStimulus("fetch_t4", mk(4, 0, F_DONE));

        // Memory read with three wait states
        applyStimulus("mrd_t1", mk(1, 1, F_ALE));
        applyStimulus("mrd_t2", mk(2, 1, F_RD));
        bus.ready = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("mrd_tw%0d", i), mk(2, 1, F_WAIT | F_RD));
        bus.ready = 1'b1;
        setDesc(2, 9, 1'b0, 1'b0);
        applyStimulus("mrd_t3", mk(3, 1, F_RD | F_DONE));

        // mc_len 9 clamps to MAX_T
        applyStimulus("len9_t1", mk(1, 2, F_ALE));
        applyStimulus("len9_t2", mk(2, 2, F_WR));
        applyStimulus("len9_t3", mk(3, 2, F_WR));
        applyStimulus("len9_t4", mk(4, 2, '0));
        setDesc(6, 1, 1'b0, 1'b0);
        bus.ready = 1'b0;
        applyStimulus("len9_t5", mk(5, 2, '0));
        applyStimulus("len9_t6", mk(6, 2, F_DONE));

        // mc_len 1 clamps to 3; bus idle ignores READY
        applyStimulus("len1_t1", mk(1, 6, F_ALE));
        setDesc(3, 4, 1'b0, 1'b0);
        applyStimulus("len1_t2", mk(2, 6, '0));
        applyStimulus("len1_t3", mk(3, 6, F_DONE));

        // READY stuck low: forced exit after WAIT_LIMIT wait states
        applyStimulus("tmo_t1", mk(1, 3, F_ALE));
        applyStimulus("tmo_t2", mk(2, 3, F_RD));
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("tmo_tw%0d", i), mk(2, 3, F_WAIT | F_RD));
        applyStimulus("tmo_t3", mk(3, 3, F_RD | F_TMO));
        bus.hold  = 1'b1;
        bus.ready = 1'b1;
        setDesc(4, 3, 1'b1, 1'b0);
        applyStimulus("tmo_t4", mk(4, 3, F_DONE));

        // HOLD ignored when the cycle was not the last of its instruction
        applyStimulus("nohold_t1", mk(1, 4, F_ALE));
        bus.hold  = 1'b0;
        bus.ready = 1'b0;
        applyStimulus("iow_t2", mk(2, 4, F_WR));
        applyStimulus("iow_tw1", mk(2, 4, F_WAIT | F_WR));
        applyStimulus("iow_tw2", mk(2, 4, F_WAIT | F_WR));
        bus.ready = 1'b1;
        applyStimulus("iow_t3", mk(3, 4, F_WR | F_DONE));

        // HOLD at end of last cycle, release back to T1
        bus.hold = 1'b1;
        setDesc(0, 3, 1'b0, 1'b0);
        applyStimulus("hold_a", mk(0, 4, F_HOLD));
        applyStimulus("hold_b", mk(0, 4, F_HOLD));
        bus.hold = 1'b0;
        applyStimulus("rel_t1", mk(1, 0, F_ALE));
        applyStimulus("rel_t2", mk(2, 0, F_RD));
        applyStimulus("rel_t3", mk(3, 0, F_RD | F_DONE));

        // HALT, HOLD from HALT, then interrupt acknowledge
        bus.halt_req = 1'b1;
        applyStimulus("halt", mk(0, 7, F_HALT));
        bus.halt_req = 1'b0;
        bus.hold     = 1'b1;
        applyStimulus("halt_hold", mk(0, 7, F_HOLD));
        bus.hold = 1'b0;
        applyStimulus("halt_back", mk(0, 7, F_HALT));
        bus.int_req = 1'b1;
        setDesc(5, 3, 1'b1, 1'b0);
        applyStimulus("ia_t1", mk(1, 5, F_ALE));
        bus.int_req = 1'b0;
        applyStimulus("ia_t2", mk(2, 5, F_INTA));
        applyStimulus("ia_t3", mk(3, 5, F_INTA | F_DONE));

        // hold and halt_req together: HOLD first, HALT on release
        bus.hold     = 1'b1;
        bus.halt_req = 1'b1;
        applyStimulus("hh_hold", mk(0, 5, F_HOLD));
        bus.hold     = 1'b0;
        bus.halt_req = 1'b0;
        applyStimulus("hh_halt", mk(0, 7, F_HALT));
        bus.int_req = 1'b1;
        setDesc(1, 4, 1'b0, 1'b0);
        applyStimulus("wake_t1", mk(1, 1, F_ALE));
        bus.int_req = 1'b0;
        applyStimulus("wake_t2", mk(2, 1, F_RD));
        applyStimulus("wake_t3", mk(3, 1, F_RD));

        // Reset in T3 aborts the cycle without a completion pulse
        reset = 1'b1;
        applyStimulus("rst_mid", mk(0, 0, '0));
        reset = 1'b0;
        setDesc(0, 5, 1'b0, 1'b0);
        applyStimulus("post_rst", mk(1, 0, F_ALE));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
